uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter, the transmit-side counterpart of the design's UART receiver. It accepts parallel bytes into an internal 16-entry FIFO and shifts them out on `serial_out` as 8N1 frames: start bit, 8 data bits LSB first, one stop bit. Bit timing comes from a baud prescaler running off the 5 MHz system clock. Back-to-back queued bytes go out with no idle gap.

## Interface
- `P_UART_WIDTH`, 8: data bits per frame.
- `P_BAUD`, 9600: line rate in bit/s.
- `P_CLK_HZ`, 5000000: system clock frequency. Bit period `LP_BIT_CYCLES` = `P_CLK_HZ / P_BAUD` = 520 cycles, integer division.
- `P_FIFO_DEPTH`, 16: transmit FIFO entries, power of two.

Ports:
- `CLK`, input, 1: system clock; all logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `data_in`, input, `P_UART_WIDTH`: byte to queue.
- `load`, input, 1: write strobe, sampled each cycle.
- `serial_out`, output, 1: TX line, idle high, registered.
- `busy`, output, 1: high while a frame is on the line.
- `fifo_full`, output, 1: FIFO holds `P_FIFO_DEPTH` words.
- `fifo_empty`, output, 1: FIFO holds 0 words.
- `overrun`, output, 1: sticky; set when `load` arrives while `fifo_full` is high.

## Operation
- FIFO
  - Write is accepted when `load`=1 and `fifo_full`=0, using the registered full flag.
  - A write while full is dropped and sets `overrun`. `overrun` clears only on `reset`.
  - Pop is internal: the FSM loads the head word into the shift register.
  - A simultaneous write and pop leaves the count unchanged. The pointers wrap modulo `P_FIFO_DEPTH`.
  - The count is `$clog2(P_FIFO_DEPTH)+1` bits wide.
- Baud counter: `$clog2(LP_BIT_CYCLES)` bits, counts 0..`LP_BIT_CYCLES`-1. `bit_done` = (count == `LP_BIT_CYCLES`-1). The counter clears on every state entry.
- FSM states:
  - `S_IDLE`: `serial_out`=1. If FIFO not empty: pop the head into `shift_reg`, `serial_out`<=0, go to `S_START`.
  - `S_START`: on `bit_done`, `serial_out`<=`shift_reg[0]`, bit index <=0, go to `S_DATA`.
  - `S_DATA`: on `bit_done`, shift `shift_reg` right and increment the index. If index == `P_UART_WIDTH`-1: `serial_out`<=1 and go to `S_STOP`. Otherwise `serial_out`<=next bit.
  - `S_STOP`: on `bit_done`, if FIFO not empty, pop, `serial_out`<=0, go to `S_START` with no idle gap. Otherwise go to `S_IDLE`.
- `busy` = (state != `S_IDLE`), combinational from the state register.
- A frame in progress always completes. No input aborts it except `reset`.

## Timing
- Reset values: `serial_out`=1, `busy`=0, `fifo_empty`=1, `fifo_full`=0, `overrun`=0, state `S_IDLE`, FIFO pointers, count and baud counter all 0.
- `reset` mid-frame: `serial_out` is high after the next edge and queued data is discarded.
- Latency: `load` sampled at edge k with the FIFO empty and state `S_IDLE` → word in FIFO after edge k → start bit (`serial_out`=0) and `busy`=1 after edge k+1.
- Every bit, stop bit included, lasts exactly `LP_BIT_CYCLES` cycles. A frame lasts `(P_UART_WIDTH+2)*LP_BIT_CYCLES` = 5200 cycles.
- Back-to-back frames: the next start bit begins on the cycle after the stop bit's last cycle.
- `busy` falls 1 cycle after the last stop-bit cycle when the FIFO is empty.
- `fifo_full` and `fifo_empty` update the cycle after the write or pop edge.
- A `load` in the same cycle the FSM pops from a full FIFO is still dropped, because acceptance uses registered `fifo_full`.

## Test plan
- Reset then idle 1000 cycles → `serial_out`=1, `busy`=0, `fifo_empty`=1, `overrun`=0.
- `load` 0xA5 once → start bit 2 cycles later; line reads 0,1,0,1,0,0,1,0,1,1, each level held 520 cycles; `busy` drops at cycle 5202.
- Load 0x00, 0xFF, 0x3C on consecutive cycles → three frames contiguous, 15600 cycles total, no idle high between a stop and the next start; sampled bytes match in order.
- Load 17 bytes while idle → the first byte is popped, 16 remain, `fifo_full`=1; a further `load` sets `overrun`=1; 17 frames are transmitted, the dropped byte never appears.
- Assert `reset` at bit 4 of a frame with 3 bytes queued → `serial_out`=1 next cycle, `fifo_empty`=1, `busy`=0, nothing transmitted for 10000 cycles.
- `load` asserted on the exact cycle the stop bit of frame 1 completes with the FIFO empty → the byte is accepted and transmitted after a one-cycle idle gap, with correct data.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a small transmit FIFO.
// Bytes queued through data_in/load are shifted out LSB first on serial_out,
// framed by a start bit (0) and a stop bit (1). Queued bytes follow each
// other with no idle gap; the line idles high.

module uart_tx #(
  parameter int P_UART_WIDTH = 8,
  parameter int P_BAUD       = 9600,
  parameter int P_CLK_HZ     = 5000000,
  parameter int P_FIFO_DEPTH = 16
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic [P_UART_WIDTH-1:0] data_in,
  input  logic                    load,
  output logic                    serial_out,
  output logic                    busy,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic                    overrun
);

  localparam int LP_BIT_CYCLES = P_CLK_HZ / P_BAUD;
  localparam int LP_BAUD_W     = $clog2(LP_BIT_CYCLES);
  localparam int LP_PTR_W      = $clog2(P_FIFO_DEPTH);
  localparam int LP_CNT_W      = LP_PTR_W + 1;
  localparam int LP_IDX_W      = $clog2(P_UART_WIDTH);

  localparam logic [LP_BAUD_W-1:0] LP_BAUD_LAST = LP_BAUD_W'(LP_BIT_CYCLES - 1);
  localparam logic [LP_CNT_W-1:0]  LP_FULL      = LP_CNT_W'(P_FIFO_DEPTH);
  localparam logic [LP_IDX_W-1:0]  LP_IDX_LAST  = LP_IDX_W'(P_UART_WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]              state;
  logic [LP_BAUD_W-1:0]    baud_cnt;
  logic                    bit_done;
  logic [P_UART_WIDTH-1:0] mem [P_FIFO_DEPTH];
  logic [LP_PTR_W-1:0]     wr_ptr;
  logic [LP_PTR_W-1:0]     rd_ptr;
  logic [LP_CNT_W-1:0]     count;
  logic [P_UART_WIDTH-1:0] shift_reg;
  logic [LP_IDX_W-1:0]     bit_idx;
  logic                    wr_en;
  logic                    pop;

  assign bit_done   = (baud_cnt == LP_BAUD_LAST);
  assign fifo_full  = (count == LP_FULL);
  assign fifo_empty = (count == '0);
  assign busy       = (state != S_IDLE);

  // Acceptance looks only at the registered full flag, so a load on the
  // same edge as a pop from a full FIFO is still dropped.
  assign wr_en = load && !fifo_full;

  // The FSM takes the head word when idle, or at the end of a stop bit.
  always_comb begin
    pop = 1'b0;
    case (state)
      S_IDLE:  pop = !fifo_empty;
      S_STOP:  pop = bit_done && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  // FIFO storage; stale words need no reset because the pointers are reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // FIFO pointers, occupancy count and sticky overrun flag.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + LP_PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + LP_PTR_W'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + LP_CNT_W'(1);
        2'b01:   count <= count - LP_CNT_W'(1);
        default: count <= count;
      endcase
      if (load && fifo_full) begin
        overrun <= 1'b1;
      end
    end
  end

  // Bit timer: held at zero while idle and restarted at every bit boundary,
  // so each state (and each data bit) starts from a fresh count.
  always_ff @(posedge CLK) begin
    if (reset || state == S_IDLE || bit_done) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + LP_BAUD_W'(1);
    end
  end

  // Frame sequencer: drives the registered line level one bit period at a time.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= S_IDLE;
      serial_out <= 1'b1;
      shift_reg  <= '0;
      bit_idx    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          serial_out <= 1'b1;
          if (pop) begin
            shift_reg  <= mem[rd_ptr];
            serial_out <= 1'b0;
            state      <= S_START;
          end
        end
        S_START: begin
          if (bit_done) begin
            serial_out <= shift_reg[0];
            bit_idx    <= '0;
            state      <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + LP_IDX_W'(1);
            if (bit_idx == LP_IDX_LAST) begin
              serial_out <= 1'b1;
              state      <= S_STOP;
            end else begin
              serial_out <= shift_reg[1];
            end
          end
        end
        S_STOP: begin
          if (bit_done) begin
            if (pop) begin
              shift_reg  <= mem[rd_ptr];
              serial_out <= 1'b0;
              state      <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state      <= S_IDLE;
          serial_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// Expected line activity is built from the frame rule directly: each byte
// becomes {stop=1, data, start=0} sent LSB first, every level held for one
// bit period, with frames placed at cycle offsets derived from load timing.

module tb_uart_tx;

  // A fast line rate keeps frames short; 5 MHz / 300000 truncates to 16 cycles.
  localparam int TB_CLK_HZ = 5000000;
  localparam int TB_BAUD   = 300000;
  localparam int BIT       = TB_CLK_HZ / TB_BAUD;
  localparam int FRAME     = 10 * BIT;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       load;
  logic       serial_out;
  logic       busy;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overrun;

  int n_cmp;
  int n_fail;

  uart_tx #(
    .P_UART_WIDTH(8),
    .P_BAUD(TB_BAUD),
    .P_CLK_HZ(TB_CLK_HZ),
    .P_FIFO_DEPTH(16)
  ) dut (
    .CLK(clk),
    .reset(reset),
    .data_in(data_in),
    .load(load),
    .serial_out(serial_out),
    .busy(busy),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .overrun(overrun)
  );

  // 5 MHz system clock.
  initial begin
    clk = 1'b0;
    forever #100 clk = ~clk;
  end

  // Drive one byte for exactly one rising edge; call and return at a negedge.
  task automatic push(input logic [7:0] b);
    data_in = b;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  // Record the line level at the start of each of 10 bit slots and whether it
  // held steady (with busy high) for the whole slot. Starts on a negedge
  // inside the first cycle of the start bit; ends one full frame later.
  task automatic capture_frame(output logic [9:0] line, output logic stable);
    stable = 1'b1;
    line   = '0;
    for (int s = 0; s < 10; s++) begin
      line[s] = serial_out;
      for (int c = 0; c < BIT; c++) begin
        if (serial_out !== line[s] || busy !== 1'b1) stable = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  // Line must stay idle-high and not busy for the given number of cycles.
  task automatic watch_quiet(input int cycles, output logic quiet);
    quiet = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      if (serial_out !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic quiet;
    reset   = 1'b1;
    load    = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({serial_out, busy, fifo_empty, fifo_full, overrun} !== 5'b10100) begin
      n_fail++;
      $display("[TB] FAIL reset_state: {line,busy,empty,full,overrun} got %b, want 10100",
               {serial_out, busy, fifo_empty, fifo_full, overrun});
    end
    watch_quiet(1000, quiet);
    n_cmp++;
    if (quiet !== 1'b1 || {fifo_empty, overrun} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL reset_idle_1000: quiet %b empty %b overrun %b, want 1 1 0",
               quiet, fifo_empty, overrun);
    end
  endtask

  task automatic test_single(input logic [7:0] b);
    logic [9:0] line;
    logic       stable;
    push(b);
    n_cmp++;
    if ({serial_out, busy, fifo_empty} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL single_queued_%02h: {line,busy,empty} got %b, want 100",
               b, {serial_out, busy, fifo_empty});
    end
    @(negedge clk);
    capture_frame(line, stable);
    n_cmp++;
    if (line !== {1'b1, b, 1'b0} || stable !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_frame_%02h: line %b steady %b, want %b steady 1",
               b, line, stable, {1'b1, b, 1'b0});
    end
    n_cmp++;
    if ({serial_out, busy, fifo_empty} !== 3'b101) begin
      n_fail++;
      $display("[TB] FAIL single_end_%02h: {line,busy,empty} got %b, want 101",
               b, {serial_out, busy, fifo_empty});
    end
  endtask

  task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1,
                                   input logic [7:0] b2);
    logic [7:0] exp [3];
    exp[0] = b0;
    exp[1] = b1;
    exp[2] = b2;
    push(b0);
    fork
      begin
        push(b1);
        push(b2);
      end
      begin
        logic [9:0] line;
        logic       stable;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          capture_frame(line, stable);
          n_cmp++;
          if (line !== {1'b1, exp[i], 1'b0} || stable !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL b2b_frame%0d: line %b steady %b, want %b steady 1",
                     i, line, stable, {1'b1, exp[i], 1'b0});
          end
        end
      end
    join
    n_cmp++;
    if ({serial_out, busy, fifo_empty} !== 3'b101) begin
      n_fail++;
      $display("[TB] FAIL b2b_end: {line,busy,empty} got %b, want 101",
               {serial_out, busy, fifo_empty});
    end
  endtask

  task automatic test_overflow();
    logic [7:0] q [17];
    logic [7:0] extra;
    logic [7:0] extra2;
    logic       quiet;
    for (int i = 0; i < 17; i++) q[i] = 8'($urandom);
    extra  = 8'($urandom);
    extra2 = 8'($urandom);
    push(q[0]);
    fork
      begin
        for (int i = 1; i < 17; i++) push(q[i]);
        n_cmp++;
        if ({fifo_full, overrun} !== 2'b10) begin
          n_fail++;
          $display("[TB] FAIL ovf_full_16: {full,overrun} got %b, want 10", {fifo_full, overrun});
        end
        push(extra);
        n_cmp++;
        if ({fifo_full, overrun} !== 2'b11) begin
          n_fail++;
          $display("[TB] FAIL ovf_overrun_set: {full,overrun} got %b, want 11", {fifo_full, overrun});
        end
        // Land the next load on the edge where the first stop bit ends and
        // the FSM pops from the still-full FIFO.
        repeat (FRAME - 17) @(negedge clk);
        push(extra2);
        n_cmp++;
        if ({fifo_full, overrun} !== 2'b01) begin
          n_fail++;
          $display("[TB] FAIL ovf_load_on_pop: {full,overrun} got %b, want 01", {fifo_full, overrun});
        end
      end
      begin
        logic [9:0] line;
        logic       stable;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
          capture_frame(line, stable);
          n_cmp++;
          if (line !== {1'b1, q[i], 1'b0} || stable !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ovf_frame%0d: line %b steady %b, want %b steady 1",
                     i, line, stable, {1'b1, q[i], 1'b0});
          end
        end
      end
    join
    watch_quiet(3 * BIT, quiet);
    n_cmp++;
    if (quiet !== 1'b1 || {fifo_empty, overrun} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL ovf_after: quiet %b empty %b overrun %b, want 1 1 1",
               quiet, fifo_empty, overrun);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b [4];
    logic       quiet;
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) push(b[i]);
    // Move to the middle of data bit 4 (frame slot 5) of the first frame.
    repeat (5 * BIT + BIT / 2 - 2) @(negedge clk);
    n_cmp++;
    if (serial_out !== b[0][4] || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midrst_bit4: line %b busy %b, want %b 1", serial_out, busy, b[0][4]);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({serial_out, busy, fifo_empty, fifo_full, overrun} !== 5'b10100) begin
      n_fail++;
      $display("[TB] FAIL midrst_state: {line,busy,empty,full,overrun} got %b, want 10100",
               {serial_out, busy, fifo_empty, fifo_full, overrun});
    end
    reset = 1'b0;
    watch_quiet(10000, quiet);
    n_cmp++;
    if (quiet !== 1'b1 || fifo_empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midrst_quiet: quiet %b empty %b, want 1 1", quiet, fifo_empty);
    end
  endtask

  task automatic test_load_at_stop();
    logic [7:0] b0;
    logic [7:0] b1;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    push(b0);
    fork
      begin
        repeat (FRAME) @(negedge clk);
        push(b1);
      end
      begin
        logic [9:0] line;
        logic       stable;
        @(negedge clk);
        capture_frame(line, stable);
        n_cmp++;
        if (line !== {1'b1, b0, 1'b0} || stable !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL stopload_frame0: line %b steady %b, want %b steady 1",
                   line, stable, {1'b1, b0, 1'b0});
        end
        n_cmp++;
        if ({serial_out, busy, fifo_empty} !== 3'b100) begin
          n_fail++;
          $display("[TB] FAIL stopload_gap: {line,busy,empty} got %b, want 100",
                   {serial_out, busy, fifo_empty});
        end
        @(negedge clk);
        capture_frame(line, stable);
        n_cmp++;
        if (line !== {1'b1, b1, 1'b0} || stable !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL stopload_frame1: line %b steady %b, want %b steady 1",
                   line, stable, {1'b1, b1, 1'b0});
        end
      end
    join
    n_cmp++;
    if ({serial_out, busy, fifo_empty} !== 3'b101) begin
      n_fail++;
      $display("[TB] FAIL stopload_end: {line,busy,empty} got %b, want 101",
               {serial_out, busy, fifo_empty});
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset   = 1'b1;
    load    = 1'b0;
    data_in = '0;
    $display("[TB] bit period %0d cycles", BIT);
    test_reset();
    test_single(8'hA5);
    test_single(8'($urandom));
    test_single(8'($urandom));
    test_back_to_back(8'h00, 8'hFF, 8'h3C);
    test_back_to_back(8'($urandom), 8'($urandom), 8'($urandom));
    test_overflow();
    test_reset_mid_frame();
    test_load_at_stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
